// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer between issue/execute and the register file.
// An entry is allocated at issue and filled in from the CDB. Entries retire in program
// order, at most one per cycle. A retiring mispredicted branch flushes the whole buffer.
// Optional feature: define ROB_CDB_BYPASS_EN to forward a CDB broadcast straight to the
// operand queries in the same cycle.
module reorder_buffer #(
  parameter int unsigned ROB_DEPTH = 16,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rdy_i,
  input  logic              issue_valid_i,
  input  logic [4:0]        issue_rd_i,
  output logic [TAG_W-1:0]  issue_tag_o,
  output logic              rob_full_o,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_value_i,
  input  logic              cdb_mispredict_i,
  input  logic [31:0]       cdb_target_i,
  input  logic [TAG_W-1:0]  query1_tag_i,
  output logic              query1_ready_o,
  output logic [DATA_W-1:0] query1_value_o,
  input  logic [TAG_W-1:0]  query2_tag_i,
  output logic              query2_ready_o,
  output logic [DATA_W-1:0] query2_value_o,
  output logic              commit_valid_o,
  output logic [4:0]        commit_index_o,
  output logic [TAG_W-1:0]  commit_tag_o,
  output logic [DATA_W-1:0] commit_value_o,
  output logic              jump_wrong_o,
  output logic [31:0]       jump_target_o
);

  localparam logic [TAG_W:0] FullCount = (TAG_W+1)'(ROB_DEPTH);

  logic [TAG_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]       count_q, count_d;
  logic [ROB_DEPTH-1:0] busy_q, busy_d, ready_q, ready_d, mispred_q, mispred_d;
  logic [4:0]           rd_q     [ROB_DEPTH];
  logic [4:0]           rd_d     [ROB_DEPTH];
  logic [DATA_W-1:0]    value_q  [ROB_DEPTH];
  logic [DATA_W-1:0]    value_d  [ROB_DEPTH];
  logic [31:0]          target_q [ROB_DEPTH];
  logic [31:0]          target_d [ROB_DEPTH];

  logic              commit_valid_q, commit_valid_d;
  logic [4:0]        commit_index_q, commit_index_d;
  logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;
  logic [DATA_W-1:0] commit_value_q, commit_value_d;
  logic              jump_wrong_q, jump_wrong_d;
  logic [31:0]       jump_target_q, jump_target_d;

  logic do_issue, do_commit, do_flush, do_cdb;

  // Full is judged on registered count only, so a same-cycle commit never frees a slot.
  assign rob_full_o  = (count_q == FullCount);
  assign issue_tag_o = tail_q;
  assign do_issue    = rdy_i & issue_valid_i & ~rob_full_o;
  assign do_commit   = rdy_i & busy_q[head_q] & ready_q[head_q];
  assign do_flush    = do_commit & mispred_q[head_q];
  assign do_cdb      = rdy_i & cdb_valid_i & busy_q[cdb_tag_i];

  assign commit_valid_o = commit_valid_q;
  assign commit_index_o = commit_index_q;
  assign commit_tag_o   = commit_tag_q;
  assign commit_value_o = commit_value_q;
  assign jump_wrong_o   = jump_wrong_q;
  assign jump_target_o  = jump_target_q;

  // Next-state: retire at head, then either flush everything or apply CDB write and issue.
  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    busy_d         = busy_q;
    ready_d        = ready_q;
    mispred_d      = mispred_q;
    rd_d           = rd_q;
    value_d        = value_q;
    target_d       = target_q;
    commit_valid_d = do_commit;
    commit_index_d = commit_index_q;
    commit_tag_d   = commit_tag_q;
    commit_value_d = commit_value_q;
    jump_wrong_d   = do_flush;
    jump_target_d  = jump_target_q;

    if (do_commit) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + TAG_W'(1);
      commit_index_d = rd_q[head_q];
      commit_tag_d   = head_q;
      commit_value_d = value_q[head_q];
    end

    if (do_flush) begin
      // Younger entries are on the wrong path; same-cycle issue and CDB writes are dropped.
      busy_d        = '0;
      ready_d       = '0;
      mispred_d     = '0;
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      jump_target_d = target_q[head_q];
    end else begin
      if (do_cdb) begin
        ready_d[cdb_tag_i]   = 1'b1;
        mispred_d[cdb_tag_i] = cdb_mispredict_i;
        value_d[cdb_tag_i]   = cdb_value_i;
        target_d[cdb_tag_i]  = cdb_target_i;
      end
      if (do_issue) begin
        busy_d[tail_q]    = 1'b1;
        ready_d[tail_q]   = 1'b0;
        mispred_d[tail_q] = 1'b0;
        rd_d[tail_q]      = issue_rd_i;
        tail_d            = tail_q + TAG_W'(1);
      end
      if (do_issue && !do_commit) begin
        count_d = count_q + (TAG_W+1)'(1);
      end else if (!do_issue && do_commit) begin
        count_d = count_q - (TAG_W+1)'(1);
      end
    end
  end

  // State and registered outputs; async reset clears everything immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      mispred_q      <= '0;
      rd_q           <= '{default: '0};
      value_q        <= '{default: '0};
      target_q       <= '{default: '0};
      commit_valid_q <= 1'b0;
      commit_index_q <= '0;
      commit_tag_q   <= '0;
      commit_value_q <= '0;
      jump_wrong_q   <= 1'b0;
      jump_target_q  <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      mispred_q      <= mispred_d;
      rd_q           <= rd_d;
      value_q        <= value_d;
      target_q       <= target_d;
      commit_valid_q <= commit_valid_d;
      commit_index_q <= commit_index_d;
      commit_tag_q   <= commit_tag_d;
      commit_value_q <= commit_value_d;
      jump_wrong_q   <= jump_wrong_d;
      jump_target_q  <= jump_target_d;
    end
  end

  // Operand lookups read latched entry state, optionally forwarding the live CDB.
  always_comb begin
    query1_ready_o = busy_q[query1_tag_i] & ready_q[query1_tag_i];
    query1_value_o = value_q[query1_tag_i];
    query2_ready_o = busy_q[query2_tag_i] & ready_q[query2_tag_i];
    query2_value_o = value_q[query2_tag_i];
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_valid_i && (cdb_tag_i == query1_tag_i)) begin
      query1_ready_o = 1'b1;
      query1_value_o = cdb_value_i;
    end
    if (cdb_valid_i && (cdb_tag_i == query2_tag_i)) begin
      query2_ready_o = 1'b1;
      query2_value_o = cdb_value_i;
    end
`endif
  end

endmodule
